// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared widths, layer state type and ReLU helper for the DNN pipeline
package dnn_pkg;

  localparam int IDX_W    = 16;
  localparam int DOUBLE_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } layer_state_t;

  // ReLU on an IEEE-754 double bit pattern: anything with the sign bit set
  // (negatives, -0.0, negative NaN) becomes +0.0; positive NaN passes through
  function automatic logic [DOUBLE_W-1:0] relu_bits(input logic [DOUBLE_W-1:0] v);
    return v[DOUBLE_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// rtl/pool_row_buffer.sv - per-column partial maxima for the current band of pooling windows
module pool_row_buffer #(
  parameter int OUT_DIM   = 2,
  parameter int DATA_SIZE = 64,
  parameter int ADDR_W    = 1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 wr_first,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] partial [OUT_DIM];

  // Values are post-ReLU (non-negative), so an unsigned compare orders them correctly
  assign rd_data = partial[addr];

  // First beat of a window overwrites the slot; later beats keep the running max
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < OUT_DIM; i++) begin
        partial[i] <= '0;
      end
    end else if (wr_en) begin
      if (wr_first || (wr_data > partial[addr])) begin
        partial[addr] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/relu_maxpool_layer.sv
// rtl/relu_maxpool_layer.sv - ReLU + non-overlapping max-pool on a raster stream (option macro: MAXPOOL_INDEX_CHECK_EN)
module relu_maxpool_layer
  import dnn_pkg::*;
#(
  parameter     NAME         = "RELU_MAXPOOL_DEFAULT_NAME",
  parameter int NUM_CHANNELS = 1,
  parameter int IN_DIM       = 4,
  parameter int POOL_DIM     = 2,
  parameter int DATA_SIZE    = DOUBLE_W,
  parameter int OUT_DIM      = IN_DIM / POOL_DIM
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [IDX_W-1:0]     in_index2,
  input  logic [IDX_W-1:0]     in_index1,
  input  logic [IDX_W-1:0]     in_index0,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [IDX_W-1:0]     out_index2,
  output logic [IDX_W-1:0]     out_index1,
  output logic [IDX_W-1:0]     out_index0,
  output logic                 frame_done
`ifdef MAXPOOL_INDEX_CHECK_EN
  ,
  output logic                 index_err
`endif
);

  localparam int               ADDR_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [IDX_W-1:0] DIM_LAST  = IDX_W'(IN_DIM - 1);
  localparam logic [IDX_W-1:0] POOL_LAST = IDX_W'(POOL_DIM - 1);
  localparam logic [IDX_W-1:0] CH_LAST   = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0] OUT_LIMIT = IDX_W'(OUT_DIM);
  localparam int               unused_name_w = $bits(NAME);

  layer_state_t state, next_state;

  // cx/cy/cc: raster position; sx/sy: offset inside the window; px/py: window column/row
  logic [IDX_W-1:0] cx, cy, cc, sx, sy, px, py;

  logic accept, x_last, y_last, frame_last;
  logic in_window, win_first, win_last, emit;
  logic [DATA_SIZE-1:0] relu_val, partial, merged;

  // clear wins over a coincident beat; there is no backpressure otherwise
  assign accept     = in_valid && !clear;
  assign x_last     = (cx == DIM_LAST);
  assign y_last     = (cy == DIM_LAST);
  assign frame_last = x_last && y_last && (cc == CH_LAST);

  // Beats past the last full window in x or y are counted but never pooled
  assign in_window  = (px < OUT_LIMIT) && (py < OUT_LIMIT);
  assign win_first  = (sx == '0) && (sy == '0);
  assign win_last   = (sx == POOL_LAST) && (sy == POOL_LAST);
  assign emit       = accept && in_window && win_last;

  generate
    if (DATA_SIZE == DOUBLE_W) begin : g_relu_double
      assign relu_val = relu_bits(in_data);
    end else begin : g_relu_generic
      assign relu_val = in_data[DATA_SIZE-1] ? '0 : in_data;
    end
  endgenerate

  assign merged = (win_first || (relu_val > partial)) ? relu_val : partial;

  pool_row_buffer #(
    .OUT_DIM   (OUT_DIM),
    .DATA_SIZE (DATA_SIZE),
    .ADDR_W    (ADDR_W)
  ) u_row_buffer (
    .clk      (clk),
    .clear    (clear),
    .wr_en    (accept && in_window),
    .wr_first (win_first),
    .addr     (px[ADDR_W-1:0]),
    .wr_data  (relu_val),
    .rd_data  (partial)
  );

  // Raster counters; window sub-counters stand in for cx/POOL_DIM and cy/POOL_DIM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {cx, cy, cc, sx, sy, px, py} <= '0;
    end else if (clear) begin
      {cx, cy, cc, sx, sy, px, py} <= '0;
    end else if (accept) begin
      if (x_last) begin
        cx <= '0;
        sx <= '0;
        px <= '0;
        if (y_last) begin
          cy <= '0;
          sy <= '0;
          py <= '0;
          cc <= (cc == CH_LAST) ? '0 : cc + 1'b1;
        end else begin
          cy <= cy + 1'b1;
          if (sy == POOL_LAST) begin
            sy <= '0;
            py <= py + 1'b1;
          end else begin
            sy <= sy + 1'b1;
          end
        end
      end else begin
        cx <= cx + 1'b1;
        if (sx == POOL_LAST) begin
          sx <= '0;
          px <= px + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame FSM: the first beat starts a frame, the last beat of the last channel ends it
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) next_state = frame_last ? IDLE : RUN;
        RUN:     if (in_valid && frame_last) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Registered result; data/index hold their last value between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_index2 <= '0;
      out_index1 <= '0;
      out_index0 <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= accept && frame_last;
      if (emit) begin
        out_data   <= merged;
        out_index2 <= cc;
        out_index1 <= py;
        out_index0 <= px;
      end
    end
  end

`ifdef MAXPOOL_INDEX_CHECK_EN
  logic idx_mismatch;

  assign idx_mismatch = {in_index2, in_index1, in_index0} != {cc, cy, cx};

  // Sticky flag for any accepted beat whose carried indices disagree with our position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_err <= 1'b0;
    end else if (clear) begin
      index_err <= 1'b0;
    end else if (accept && idx_mismatch) begin
      index_err <= 1'b1;
`ifndef SYNTHESIS
      $display("%s: index mismatch, got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
               NAME, in_index2, in_index1, in_index0, cc, cy, cx);
`endif
    end
  end
`else
  logic unused_index;

  assign unused_index = ^{in_index2, in_index1, in_index0};
`endif

endmodule

// File: tb/tb_relu_maxpool_layer.sv
// tb/tb_relu_maxpool_layer.sv - scoreboard bench for relu_maxpool_layer
`timescale 1ns/1ps
module tb_relu_maxpool_layer;

  typedef struct {
    logic [63:0] d;
    logic [15:0] i2;
    logic [15:0] i1;
    logic [15:0] i0;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, in_valid;
  logic [63:0] in_data;
  logic [15:0] in_index2, in_index1, in_index0;
  int          sel;

  logic        a_valid, b_valid, c_valid, a_fd, b_fd, c_fd;
  logic [63:0] a_data, b_data, c_data;
  logic [15:0] a_i2, a_i1, a_i0, b_i2, b_i1, b_i0, c_i2, c_i1, c_i0;
`ifdef MAXPOOL_INDEX_CHECK_EN
  logic        a_err, b_err, c_err;
`endif

  logic        o_valid, o_fd;
  logic [63:0] o_data;
  logic [15:0] o_i2, o_i1, o_i0;

  exp_t        exp_q[$];
  exp_t        e;
  logic [63:0] img [0:1][0:4][0:4];
  logic        fd_due;
  int          n_cmp, n_bad, n_out;

  relu_maxpool_layer #(.NAME("POOL_A"), .NUM_CHANNELS(1), .IN_DIM(4), .POOL_DIM(2), .DATA_SIZE(64)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid && sel == 0), .in_data(in_data),
    .in_index2(in_index2), .in_index1(in_index1), .in_index0(in_index0),
    .out_valid(a_valid), .out_data(a_data), .out_index2(a_i2), .out_index1(a_i1), .out_index0(a_i0),
    .frame_done(a_fd)
`ifdef MAXPOOL_INDEX_CHECK_EN
    , .index_err(a_err)
`endif
  );

  relu_maxpool_layer #(.NAME("POOL_B"), .NUM_CHANNELS(1), .IN_DIM(5), .POOL_DIM(2), .DATA_SIZE(64)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid && sel == 1), .in_data(in_data),
    .in_index2(in_index2), .in_index1(in_index1), .in_index0(in_index0),
    .out_valid(b_valid), .out_data(b_data), .out_index2(b_i2), .out_index1(b_i1), .out_index0(b_i0),
    .frame_done(b_fd)
`ifdef MAXPOOL_INDEX_CHECK_EN
    , .index_err(b_err)
`endif
  );

  relu_maxpool_layer #(.NAME("POOL_C"), .NUM_CHANNELS(2), .IN_DIM(4), .POOL_DIM(2), .DATA_SIZE(64)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid && sel == 2), .in_data(in_data),
    .in_index2(in_index2), .in_index1(in_index1), .in_index0(in_index0),
    .out_valid(c_valid), .out_data(c_data), .out_index2(c_i2), .out_index1(c_i1), .out_index0(c_i0),
    .frame_done(c_fd)
`ifdef MAXPOOL_INDEX_CHECK_EN
    , .index_err(c_err)
`endif
  );

  always_comb begin
    o_valid = a_valid; o_data = a_data; o_i2 = a_i2; o_i1 = a_i1; o_i0 = a_i0; o_fd = a_fd;
    if (sel == 1) begin
      o_valid = b_valid; o_data = b_data; o_i2 = b_i2; o_i1 = b_i1; o_i0 = b_i0; o_fd = b_fd;
    end else if (sel == 2) begin
      o_valid = c_valid; o_data = c_data; o_i2 = c_i2; o_i1 = c_i1; o_i0 = c_i0; o_fd = c_fd;
    end
  end

  function automatic logic [63:0] relu_ref(input logic [63:0] v);
    return v[63] ? 64'h0 : v;
  endfunction

  // Max over one 2x2 window of the stored frame, from scratch
  function automatic logic [63:0] win_max(input int c, input int py, input int px);
    logic [63:0] m;
    m = 64'h0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (relu_ref(img[c][py*2+dy][px*2+dx]) > m) m = relu_ref(img[c][py*2+dy][px*2+dx]);
    return m;
  endfunction

  task automatic put_beat(input int c, input int y, input int x, input int in_dim, input int nch,
                          input bit push_model);
    int od;
    od = in_dim / 2;
    in_valid  = 1'b1;
    clear     = 1'b0;
    in_data   = img[c][y][x];
    in_index2 = 16'(c);
    in_index1 = 16'(y);
    in_index0 = 16'(x);
    if (push_model && (x % 2 == 1) && (y % 2 == 1) && (x / 2 < od) && (y / 2 < od))
      exp_q.push_back('{win_max(c, y / 2, x / 2), 16'(c), 16'(y / 2), 16'(x / 2)});
    if (c == nch - 1 && y == in_dim - 1 && x == in_dim - 1) fd_due = 1'b1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic fill_ramp();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        img[0][y][x] = $realtobits(real'(y * 4 + x + 1));
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 0; fd_due = 1'b0;
    go_idle();
    in_data = '0; in_index2 = '0; in_index1 = '0; in_index0 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({a_valid, b_valid, c_valid, a_fd, b_fd, c_fd} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got %b required 000000", {a_valid, b_valid, c_valid, a_fd, b_fd, c_fd});
    end
    n_cmp++;
    if ({a_data, a_i2, a_i1, a_i0} !== '0) begin
      n_bad++; $display("FAIL reset_out got %h required 0", {a_data, a_i2, a_i1, a_i0});
    end
`ifdef MAXPOOL_INDEX_CHECK_EN
    n_cmp++;
    if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_index_err got %b required 0", a_err); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    sel = 0;
    fill_ramp();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL basic_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL basic_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL basic_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 16) begin
        put_beat(0, k / 4, k % 4, 4, 1, 1'b0);
        case (k)
          5:  exp_q.push_back('{$realtobits(6.0),  16'd0, 16'd0, 16'd0});
          7:  exp_q.push_back('{$realtobits(8.0),  16'd0, 16'd0, 16'd1});
          13: exp_q.push_back('{$realtobits(14.0), 16'd0, 16'd1, 16'd0});
          15: exp_q.push_back('{$realtobits(16.0), 16'd0, 16'd1, 16'd1});
          default: ;
        endcase
      end else go_idle();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_negative();
    sel = 0;
    for (int k = 0; k < 16; k++) img[0][k / 4][k % 4] = (k == 9) ? 64'h8000_0000_0000_0000 : $realtobits(-3.5);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL neg_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL neg_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL neg_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 16) begin
        put_beat(0, k / 4, k % 4, 4, 1, 1'b0);
        if ((k % 2 == 1) && ((k / 4) % 2 == 1))
          exp_q.push_back('{64'h0, 16'd0, 16'(k / 8), 16'((k % 4) / 2)});
      end else go_idle();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL neg_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_crop();
    sel = 1; n_out = 0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        img[0][y][x] = (y == 4 || x == 4) ? $realtobits(100.0) :
                       ((x + y) % 3 == 0) ? $realtobits(-real'(y * 5 + x + 1)) : $realtobits(real'(y * 5 + x + 1));
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL crop_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++; n_out++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL crop_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL crop_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 25) put_beat(0, k / 5, k % 5, 5, 1, 1'b1);
      else go_idle();
    end
    n_cmp++;
    if (n_out != 4) begin n_bad++; $display("FAIL crop_count got %0d required 4", n_out); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL crop_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    sel = 2; n_out = 0;
    for (int c = 0; c < 2; c++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++)
          img[c][y][x] = $realtobits(real'($urandom_range(0, 400)) / 4.0 - 50.0);
    img[0][0][0] = 64'hFFF8_0000_0000_0001;
    img[1][2][3] = 64'h7FF8_0000_0000_0001;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL b2b_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++; n_out++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL b2b_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL b2b_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 32) put_beat(k / 16, (k / 4) % 4, k % 4, 4, 2, 1'b1);
      else go_idle();
    end
    n_cmp++;
    if (n_out != 8) begin n_bad++; $display("FAIL b2b_count got %0d required 8", n_out); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midframe();
    sel = 0;
    for (int k = 0; k < 16; k++) img[0][k / 4][k % 4] = $realtobits(50.0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_early_valid got %b required 0", o_valid); end
      put_beat(0, k / 4, k % 4, 4, 1, 1'b0);
    end
    @(negedge clk);
    go_idle();
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({o_valid, o_fd, o_data} !== '0) begin n_bad++; $display("FAIL rst_mid_out got %h required 0", {o_valid, o_fd, o_data}); end
    @(negedge clk);
    reset = 1'b0;
    fill_ramp();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL rst_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL rst_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL rst_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 16) put_beat(0, k / 4, k % 4, 4, 1, 1'b1);
      else go_idle();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rst_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  // A window completes, then clear arrives with a beat: the earlier result still shows, the beat is dropped
  task automatic test_clear();
    sel = 0;
    fill_ramp();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_fd !== fd_due) begin n_bad++; $display("FAIL clr_frame_done got %b required %b", o_fd, fd_due); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL clr_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL clr_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 6) put_beat(0, k / 4, k % 4, 4, 1, 1'b1);
      else if (k == 6) begin
        in_valid = 1'b1; clear = 1'b1; in_data = $realtobits(100.0);
      end else if (k < 23) put_beat(0, (k - 7) / 4, (k - 7) % 4, 4, 1, 1'b1);
      else go_idle();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL clr_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

`ifdef MAXPOOL_INDEX_CHECK_EN
  task automatic test_index_check();
    sel = 0;
    fill_ramp();
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      n_cmp++;
      if (a_err !== (k >= 4)) begin n_bad++; $display("FAIL idx_err got %b required %b at step %0d", a_err, (k >= 4), k); end
      fd_due = 1'b0;
      if (o_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL idx_extra got %h required no output", o_data); end
        else begin
          e = exp_q.pop_front();
          if ({o_data, o_i2, o_i1, o_i0} !== {e.d, e.i2, e.i1, e.i0}) begin
            n_bad++; $display("FAIL idx_out got %h (%0d,%0d,%0d) required %h (%0d,%0d,%0d)",
                              o_data, o_i2, o_i1, o_i0, e.d, e.i2, e.i1, e.i0);
          end
        end
      end
      if (k < 16) begin
        put_beat(0, k / 4, k % 4, 4, 1, 1'b1);
        if (k == 3) in_index0 = 16'd7;
      end else go_idle();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL idx_missing got %0d pending required 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (a_err !== 1'b0) begin n_bad++; $display("FAIL idx_err_clear got %b required 0", a_err); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_basic();
    test_negative();
    test_crop();
    test_back_to_back();
    test_reset_midframe();
    test_clear();
`ifdef MAXPOOL_INDEX_CHECK_EN
    test_index_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
